// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Finds the youngest pending queue entry whose address matches one read port.
module wb_fwd_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_req_t               queue_i [DEPTH],
    input  logic [PTR_W-1:0]      head_i,
    input  logic [PTR_W:0]        count_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  hit_o,
    output logic [REG_DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from head towards tail so the last match found is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_i) && (queue_i[idx].addr == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = queue_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 3R/1W register-file RAM: buffers up to two
// writes per cycle, drains one per cycle, and forwards pending data to readers.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb0_valid_i,
    input  logic [REG_ADDR_W-1:0] wb0_addr_i,
    input  logic [WIDTH-1:0]      wb0_data_i,
    input  logic                  wb1_valid_i,
    input  logic [REG_ADDR_W-1:0] wb1_addr_i,
    input  logic [WIDTH-1:0]      wb1_data_i,
    output logic                  wb_ready_o,
    input  logic [REG_ADDR_W-1:0] rd0_addr_i,
    input  logic [REG_ADDR_W-1:0] rd1_addr_i,
    input  logic [REG_ADDR_W-1:0] rd2_addr_i,
    output logic [WIDTH-1:0]      rd0_data_o,
    output logic [WIDTH-1:0]      rd1_data_o,
    output logic [WIDTH-1:0]      rd2_data_o,
    output logic [REG_ADDR_W-1:0] ram_addr0_o,
    output logic [REG_ADDR_W-1:0] ram_addr1_o,
    output logic [REG_ADDR_W-1:0] ram_addr2_o,
    input  logic [WIDTH-1:0]      ram_dout0_i,
    input  logic [WIDTH-1:0]      ram_dout1_i,
    input  logic [WIDTH-1:0]      ram_dout2_i,
    output logic [REG_ADDR_W-1:0] ram_addrw_o,
    output logic [WIDTH-1:0]      ram_din_o,
    output logic                  ram_wea_o,
    output logic                  empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          queue_q [DEPTH];
    wb_req_t          queue_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, slot1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             en0, en1, pop;

    assign wb_ready_o = (count_q <= CNT_W'(DEPTH - 2));

    always_comb begin
        queue_d = queue_q;
        en0     = wb0_valid_i && wb_ready_o && (wb0_addr_i != '0);
        en1     = wb1_valid_i && wb_ready_o && (wb1_addr_i != '0);
        pop     = (count_q != '0);
        slot1   = en0 ? tail_q + PTR_W'(1) : tail_q;
        if (en0) queue_d[tail_q] = '{addr: wb0_addr_i, data: wb0_data_i};
        if (en1) queue_d[slot1]  = '{addr: wb1_addr_i, data: wb1_data_i};
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(en0) + PTR_W'(en1);
        count_d = count_q + CNT_W'(en0) + CNT_W'(en1) - CNT_W'(pop);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            queue_q <= queue_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    // Head entry is presented to the RAM and popped at the same edge.
    assign ram_wea_o   = !empty_q;
    assign ram_addrw_o = queue_q[head_q].addr;
    assign ram_din_o   = queue_q[head_q].data;
    assign empty_o     = empty_q;

    assign ram_addr0_o = rd0_addr_i;
    assign ram_addr1_o = rd1_addr_i;
    assign ram_addr2_o = rd2_addr_i;

    logic [REG_ADDR_W-1:0] rd_addr  [3];
    logic [WIDTH-1:0]      ram_dout [3];
    logic [WIDTH-1:0]      rd_data  [3];
    logic [REG_DATA_W-1:0] fwd_data [3];
    logic                  fwd_hit  [3];

    assign rd_addr[0]  = rd0_addr_i;
    assign rd_addr[1]  = rd1_addr_i;
    assign rd_addr[2]  = rd2_addr_i;
    assign ram_dout[0] = ram_dout0_i;
    assign ram_dout[1] = ram_dout1_i;
    assign ram_dout[2] = ram_dout2_i;

    for (genvar k = 0; k < 3; k++) begin : g_rd
        wb_fwd_match #(.DEPTH(DEPTH)) u_match (
            .queue_i   (queue_q),
            .head_i    (head_q),
            .count_i   (count_q),
            .rd_addr_i (rd_addr[k]),
            .hit_o     (fwd_hit[k]),
            .data_o    (fwd_data[k])
        );
        // r0 is hardwired to zero regardless of what the RAM holds there.
        assign rd_data[k] = (rd_addr[k] == '0) ? '0 :
                            fwd_hit[k]         ? fwd_data[k] : ram_dout[k];
    end

    assign rd0_data_o = rd_data[0];
    assign rd1_data_o = rd_data[1];
    assign rd2_data_o = rd_data[2];

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back front end for the 32-entry, 3-read/1-write register-file RAM.
- Accepts up to two write-back requests per cycle from the two issue pipes and buffers them in a small in-order queue.
- Drains the queue onto the RAM's single write port, one entry per cycle.
- Forwards pending (not yet written) values onto the three RAM read ports, so readers always see architecturally-latest data.

Parameters:
- WIDTH, 32, data width of one register; must match the RAM WIDTH.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid_i  in  1  write-back request, pipe 0 (older within a cycle).
- wb0_addr_i  in  5  destination register, pipe 0.
- wb0_data_i  in  WIDTH  write data, pipe 0.
- wb1_valid_i  in  1  write-back request, pipe 1 (younger within a cycle).
- wb1_addr_i  in  5  destination register, pipe 1.
- wb1_data_i  in  WIDTH  write data, pipe 1.
- wb_ready_o  out  1  queue can absorb two requests this cycle.
- rd0_addr_i, rd1_addr_i, rd2_addr_i  in  5 each  reader addresses.
- rd0_data_o, rd1_data_o, rd2_data_o  out  WIDTH each  forwarded read data.
- ram_addr0_o, ram_addr1_o, ram_addr2_o  out  5 each  RAM read addresses (equal to rdN_addr_i).
- ram_dout0_i, ram_dout1_i, ram_dout2_i  in  WIDTH each  RAM combinational read data.
- ram_addrw_o  out  5  RAM write address.
- ram_din_o  out  WIDTH  RAM write data.
- ram_wea_o  out  1  RAM write enable.
- empty_o  out  1  no pending writes.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous, active-low.
- Reset state:
  - Queue flushed: head = tail = count = 0.
  - ram_wea_o = 0, ram_addrw_o = 0, ram_din_o = 0.
  - empty_o = 1, wb_ready_o = 1.
  - Reset mid-operation discards all pending writes; the RAM contents are not touched.
- Queue storage: circular buffer of DEPTH entries {addr[4:0], data}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Enqueue:
  - A request enqueues when valid is high, wb_ready_o is high, and addr != 0. Writes to r0 are silently dropped and consume no slot.
  - Both valid: wb0 goes to tail, wb1 to tail+1.
  - Only wb1 valid: wb1 goes to tail.
  - Same address on both pipes: both are enqueued, so wb1's value is the final one.
- Ready: wb_ready_o = (count <= DEPTH-2), decoded from registered count only. It has no combinational path from the wb inputs.
- Upstream contract: valid asserted while wb_ready_o is low is a protocol violation. The request is ignored, and the bench asserts that this never happens.
- Drain:
  - When count != 0, ram_wea_o = 1, ram_addrw_o = head.addr, ram_din_o = head.data, all driven from registers.
  - The head pops at the clock edge, i.e. the RAM write and the pop happen at the same edge.
  - Latency: a request enqueued at edge N is written to the RAM at edge N+1.
  - When count == 0, ram_wea_o = 0; ram_addrw_o and ram_din_o hold don't-care values (drive the head slot).
- Simultaneous events: enqueue of 0/1/2 entries and a pop in the same cycle are legal. count_next = count + enq_cnt - pop.
- Forwarding, per read port k, combinational:
  - ram_addrk_o = rdk_addr_i.
  - If any valid queue entry (including the head being written this cycle) has addr == rdk_addr_i, rdk_data_o = data of the youngest such entry (closest to tail).
  - Otherwise rdk_data_o = ram_doutk_i.
  - rdk_addr_i == 0 always returns 0.
  - There is no bypass from the same-cycle wb inputs; the issue stage handles that.
- Entry validity: an entry is valid iff its distance from head (mod DEPTH) < count.
- empty_o = (count == 0), from a register.

Decomposition:
- Shared package regfile_pkg:
  - constant REG_ADDR_W = 5.
  - typedef wb_req_t {logic [REG_ADDR_W-1:0] addr; logic [WIDTH-1:0] data;}; the package uses the default WIDTH, 32.
- Sub-module wb_fwd_match: given the queue array, head, count and one read address, returns {hit, data} for the youngest match. It is instantiated three times.

Test Plan:
- Single write: wb0 {addr 5, data 0xDEAD_BEEF} at cycle 0 → ram_wea_o = 1, addrw = 5, din = 0xDEAD_BEEF in cycle 1. empty_o returns to 1 after the edge ending cycle 1, so it reads 1 in cycle 2.
- Dual same-address: wb0 {7, 0x1}, wb1 {7, 0x2} in one cycle → rd0_addr_i = 7 reads 0x2 on the next cycle. RAM writes 0x1 then 0x2 on consecutive cycles.
- r0 drop: wb0 {0, 0xFFFF_FFFF} alone → no enqueue, empty_o stays 1, ram_wea_o stays 0. rd1_addr_i = 0 reads 0.
- Backpressure and wrap: drive two valid requests every cycle for 8 cycles, honouring ready. wb_ready_o must fall whenever count > 2. All writes reach the RAM in order with no loss and no duplicates, and the pointers wrap at least twice.
- Forwarding priority: queue holds {3, 0xA} (head) and {3, 0xB}; ram_dout2_i = 0x0 → rd2_data_o = 0xB. After both drain, the value passes through from the RAM.
- Reset mid-op: three entries pending, rst_n low for 1 cycle → ram_wea_o = 0 immediately (asynchronous), empty_o = 1, wb_ready_o = 1. rd0_data_o equals ram_dout0_i.
